// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port general-purpose register file with HI/LO.
//
// After reset the file sweeps every register to its initial value (zero,
// except the stack pointer, which gets SP_INIT). When the sweep finishes,
// ready goes high and the file starts serving requests.
//
// Ports:
//   clk, rst_n        rising-edge clock; synchronous active-low reset
//   rd_en/rd_addr     NRD read ports; rd_data is registered (1-cycle latency)
//   wr_en/wr_addr/    NWR write ports; the highest port index wins when
//   wr_data           several ports hit the same address
//   hilo_we/hi_in/    HI/LO load; hi_out/lo_out are registered
//   lo_in
//   ready             high once the clear sweep is done
//   a0/v0             combinational taps of regs[A0_IDX] / regs[V0_IDX]
module regfile_mp #(
  parameter int unsigned         DATA_W  = 32,
  parameter int unsigned         ADDR_W  = 5,
  parameter int unsigned         NRD     = 2,
  parameter int unsigned         NWR     = 1,
  parameter int unsigned         BYPASS  = 1,
  parameter int unsigned         SP_IDX  = 29,
  parameter logic [DATA_W-1:0]   SP_INIT = 32'h7FFF_FFFC,
  parameter int unsigned         A0_IDX  = 4,
  parameter int unsigned         V0_IDX  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NRD-1:0]         rd_en,
  input  logic [NRD*ADDR_W-1:0]  rd_addr,
  output logic [NRD*DATA_W-1:0]  rd_data,
  input  logic [NWR-1:0]         wr_en,
  input  logic [NWR*ADDR_W-1:0]  wr_addr,
  input  logic [NWR*DATA_W-1:0]  wr_data,
  input  logic                   hilo_we,
  input  logic [DATA_W-1:0]      hi_in,
  input  logic [DATA_W-1:0]      lo_in,
  output logic [DATA_W-1:0]      hi_out,
  output logic [DATA_W-1:0]      lo_out,
  output logic                   ready,
  output logic [DATA_W-1:0]      a0,
  output logic [DATA_W-1:0]      v0
);

  localparam int unsigned        DEPTH    = 1 << ADDR_W;
  // ptr is one bit wider than an address so the last index is reached
  // without the counter wrapping back to zero.
  localparam logic [ADDR_W:0]    PTR_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]    PTR_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0]  SP_ADDR  = ADDR_W'(SP_IDX);
  localparam logic [ADDR_W-1:0]  A0_ADDR  = ADDR_W'(A0_IDX);
  localparam logic [ADDR_W-1:0]  V0_ADDR  = ADDR_W'(V0_IDX);
  localparam logic [ADDR_W-1:0]  ZERO_ADDR = '0;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_W:0]         ptr_q, ptr_d;
  logic                    ready_q, ready_d;
  logic [NRD*DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [DATA_W-1:0]       hi_q, hi_d;
  logic [DATA_W-1:0]       lo_q, lo_d;
  logic [DATA_W-1:0]       regs_q [DEPTH];
  logic [DATA_W-1:0]       regs_d [DEPTH];

  logic [ADDR_W-1:0]       ptr_addr_s;
  logic [ADDR_W-1:0]       waddr_s;
  logic [ADDR_W-1:0]       raddr_s;

  assign ptr_addr_s = ptr_q[ADDR_W-1:0];

  // Next-state logic: sweep in CLEAR, writes/reads/HI-LO in RUN.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ready_d   = ready_q;
    rd_data_d = rd_data_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    regs_d    = regs_q;
    waddr_s   = ZERO_ADDR;
    raddr_s   = ZERO_ADDR;

    case (state_q)
      ST_CLEAR: begin
        regs_d[ptr_addr_s] = (ptr_addr_s == SP_ADDR) ? SP_INIT : '0;
        rd_data_d          = '0;
        ptr_d              = ptr_q + PTR_ONE;
        if (ptr_q == PTR_LAST) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end else begin
          state_d = ST_CLEAR;
          ready_d = 1'b0;
        end
      end

      ST_RUN: begin
        // Ascending port order: a later (higher) port overwrites an earlier one.
        for (int p = 0; p < int'(NWR); p++) begin
          waddr_s = wr_addr[p*ADDR_W +: ADDR_W];
          if (wr_en[p] && (waddr_s != ZERO_ADDR)) begin
            regs_d[waddr_s] = wr_data[p*DATA_W +: DATA_W];
          end else begin
            regs_d[waddr_s] = regs_d[waddr_s];
          end
        end

        // regs_d already carries the winning write and keeps r0 at zero,
        // so bypass is simply a read of the post-write view.
        for (int i = 0; i < int'(NRD); i++) begin
          raddr_s = rd_addr[i*ADDR_W +: ADDR_W];
          if (rd_en[i]) begin
            rd_data_d[i*DATA_W +: DATA_W] = (BYPASS != 0) ? regs_d[raddr_s] : regs_q[raddr_s];
          end else begin
            rd_data_d[i*DATA_W +: DATA_W] = rd_data_q[i*DATA_W +: DATA_W];
          end
        end

        if (hilo_we) begin
          hi_d = hi_in;
          lo_d = lo_in;
        end else begin
          hi_d = hi_q;
          lo_d = lo_q;
        end
      end

      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  // State registers; the array is not reset because the sweep clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      ptr_q     <= '0;
      ready_q   <= 1'b0;
      rd_data_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      ready_q   <= ready_d;
      rd_data_q <= rd_data_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      regs_q    <= regs_d;
    end
  end

  assign rd_data = rd_data_q;
  assign hi_out  = hi_q;
  assign lo_out  = lo_q;
  assign ready   = ready_q;
  assign a0      = regs_q[A0_ADDR];
  assign v0      = regs_q[V0_ADDR];

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances share stimulus, dut_a (NWR=2, BYPASS=1)
// and dut_b (NWR=1, BYPASS=0, driven from write port 0 only).
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam logic [DW-1:0] SP = 32'h7FFF_FFFC;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] rd_en;
  logic [2*AW-1:0] rd_addr;
  logic [1:0] wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*DW-1:0] wr_data;
  logic hilo_we;
  logic [DW-1:0] hi_in, lo_in;
  logic [2*DW-1:0] rd_a, rd_b;
  logic [DW-1:0] hi_a, lo_a, hi_b, lo_b, a0_a, v0_a, a0_b, v0_b;
  logic ready_a, ready_b;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain register arrays updated from the rules.
  logic [DW-1:0] ma [32];
  logic [DW-1:0] mb [32];
  logic [DW-1:0] erd_a [2];
  logic [DW-1:0] erd_b [2];
  logic [DW-1:0] ehi, elo;
  bit model_run = 1'b0;

  always #5 clk = ~clk;

  regfile_mp #(.NRD(2), .NWR(2), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .hilo_we(hilo_we),
    .hi_in(hi_in), .lo_in(lo_in), .hi_out(hi_a), .lo_out(lo_a), .ready(ready_a),
    .a0(a0_a), .v0(v0_a));

  regfile_mp #(.NRD(2), .NWR(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_b),
    .wr_en(wr_en[0:0]), .wr_addr(wr_addr[AW-1:0]), .wr_data(wr_data[DW-1:0]),
    .hilo_we(hilo_we), .hi_in(hi_in), .lo_in(lo_in), .hi_out(hi_b), .lo_out(lo_b),
    .ready(ready_b), .a0(a0_b), .v0(v0_b));

  task automatic idle();
    rd_en = 2'b00; wr_en = 2'b00; hilo_we = 1'b0;
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      ma[r] = (r == 29) ? SP : 32'h0;
      mb[r] = (r == 29) ? SP : 32'h0;
    end
    erd_a[0] = 32'h0; erd_a[1] = 32'h0; erd_b[0] = 32'h0; erd_b[1] = 32'h0;
    ehi = 32'h0; elo = 32'h0;
  endtask

  // Advance one clock; the model consumes the inputs currently driven.
  task automatic tick();
    logic [DW-1:0] va;
    logic [AW-1:0] ad;
    if (model_run) begin
      for (int i = 0; i < 2; i++) begin
        if (rd_en[i]) begin
          ad = rd_addr[i*AW +: AW];
          va = ma[ad];
          for (int p = 0; p < 2; p++)
            if (ad != 5'd0 && wr_en[p] && wr_addr[p*AW +: AW] == ad) va = wr_data[p*DW +: DW];
          erd_a[i] = va;
          erd_b[i] = mb[ad];
        end
      end
      for (int p = 0; p < 2; p++)
        if (wr_en[p] && wr_addr[p*AW +: AW] != 5'd0) ma[wr_addr[p*AW +: AW]] = wr_data[p*DW +: DW];
      if (wr_en[0] && wr_addr[AW-1:0] != 5'd0) mb[wr_addr[AW-1:0]] = wr_data[DW-1:0];
      if (hilo_we) begin ehi = hi_in; elo = lo_in; end
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    model_run = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // Writes and HI/LO loads during the sweep must be ignored.
    wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {32'hFFFF_0003, 32'hEEEE_0003};
    hilo_we = 1'b1; hi_in = 32'hFF; lo_in = 32'hEE; rd_en = 2'b11; rd_addr = {5'd29, 5'd3};
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); @(negedge clk);
      n_checks++; if (ready_a !== (k == 32)) begin n_errors++; $display("FAIL reset_ready_a cycle %0d got %b want %b", k, ready_a, (k == 32)); end
      n_checks++; if (ready_b !== (k == 32)) begin n_errors++; $display("FAIL reset_ready_b cycle %0d got %b want %b", k, ready_b, (k == 32)); end
      n_checks++; if (rd_a !== 64'h0) begin n_errors++; $display("FAIL reset_rd_hold cycle %0d got %h want 0", k, rd_a); end
      if (k >= 3) begin
        n_checks++; if (v0_a !== 32'h0) begin n_errors++; $display("FAIL sweep_v0 cycle %0d got %h want 0", k, v0_a); end
      end
    end
    idle();
    model_clear();
    model_run = 1'b1;
    n_checks++; if (hi_a !== 32'h0 || lo_a !== 32'h0) begin n_errors++; $display("FAIL reset_hilo got %h/%h want 0/0", hi_a, lo_a); end
    for (int r = 0; r < 32; r++) begin
      idle(); rd_en = 2'b11; rd_addr = {5'(31 - r), 5'(r)};
      tick();
      n_checks++; if (rd_a[DW-1:0] !== ((r == 29) ? SP : 32'h0)) begin n_errors++; $display("FAIL clear_val_a r%0d got %h want %h", r, rd_a[DW-1:0], (r == 29) ? SP : 32'h0); end
      n_checks++; if (rd_b[2*DW-1:DW] !== ((31 - r == 29) ? SP : 32'h0)) begin n_errors++; $display("FAIL clear_val_b r%0d got %h want %h", 31 - r, rd_b[2*DW-1:DW], (31 - r == 29) ? SP : 32'h0); end
    end
  endtask

  task automatic test_write_read();
    idle(); wr_en = 2'b01; wr_addr[AW-1:0] = 5'd5; wr_data[DW-1:0] = 32'hDEAD_BEEF;
    tick();
    idle(); rd_en = 2'b01; rd_addr[AW-1:0] = 5'd5;
    tick();
    n_checks++; if (rd_a[DW-1:0] !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL wr_rd_a got %h want deadbeef", rd_a[DW-1:0]); end
    n_checks++; if (rd_b[DW-1:0] !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL wr_rd_b got %h want deadbeef", rd_b[DW-1:0]); end
    // r0 write with a same-cycle read of r0: bypass must not leak the data.
    idle(); wr_en = 2'b01; wr_addr[AW-1:0] = 5'd0; wr_data[DW-1:0] = 32'h1234; rd_en = 2'b01; rd_addr[AW-1:0] = 5'd0;
    tick();
    n_checks++; if (rd_a[DW-1:0] !== 32'h0) begin n_errors++; $display("FAIL r0_bypass got %h want 0", rd_a[DW-1:0]); end
    idle(); rd_en = 2'b11; rd_addr = {5'd0, 5'd0};
    tick();
    n_checks++; if (rd_a[DW-1:0] !== 32'h0 || rd_a[2*DW-1:DW] !== 32'h0) begin n_errors++; $display("FAIL r0_read got %h want 0", rd_a); end
  endtask

  task automatic test_bypass();
    idle(); wr_en = 2'b01; wr_addr[AW-1:0] = 5'd7; wr_data[DW-1:0] = 32'hA5A5_A5A5;
    rd_en = 2'b10; rd_addr[2*AW-1:AW] = 5'd7;
    tick();
    n_checks++; if (rd_a[2*DW-1:DW] !== 32'hA5A5_A5A5) begin n_errors++; $display("FAIL bypass_on got %h want a5a5a5a5", rd_a[2*DW-1:DW]); end
    n_checks++; if (rd_b[2*DW-1:DW] !== 32'h0) begin n_errors++; $display("FAIL bypass_off got %h want 0", rd_b[2*DW-1:DW]); end
    idle(); rd_en = 2'b10; rd_addr[2*AW-1:AW] = 5'd7;
    tick();
    n_checks++; if (rd_b[2*DW-1:DW] !== 32'hA5A5_A5A5) begin n_errors++; $display("FAIL bypass_after got %h want a5a5a5a5", rd_b[2*DW-1:DW]); end
  endtask

  task automatic test_multiwrite();
    idle(); wr_en = 2'b11; wr_addr = {5'd9, 5'd9}; wr_data = {32'h2, 32'h1};
    tick();
    idle(); rd_en = 2'b01; rd_addr[AW-1:0] = 5'd9;
    tick();
    n_checks++; if (rd_a[DW-1:0] !== 32'h2) begin n_errors++; $display("FAIL multiwrite_a got %h want 2", rd_a[DW-1:0]); end
    n_checks++; if (rd_b[DW-1:0] !== 32'h1) begin n_errors++; $display("FAIL multiwrite_b got %h want 1", rd_b[DW-1:0]); end
    for (int k = 0; k < 3; k++) begin
      idle(); rd_addr = 10'($urandom); wr_en = 2'b01; wr_addr[AW-1:0] = 5'd9; wr_data[DW-1:0] = 32'h99;
      tick();
      n_checks++; if (rd_a[DW-1:0] !== 32'h2) begin n_errors++; $display("FAIL rd_hold_a got %h want 2", rd_a[DW-1:0]); end
      n_checks++; if (rd_b[DW-1:0] !== 32'h1) begin n_errors++; $display("FAIL rd_hold_b got %h want 1", rd_b[DW-1:0]); end
    end
  endtask

  task automatic test_hilo_taps();
    idle(); hilo_we = 1'b1; hi_in = 32'h11; lo_in = 32'h22;
    tick();
    idle();
    n_checks++; if (hi_a !== 32'h11 || hi_b !== 32'h11) begin n_errors++; $display("FAIL hi_load got %h/%h want 11", hi_a, hi_b); end
    n_checks++; if (lo_a !== 32'h22 || lo_b !== 32'h22) begin n_errors++; $display("FAIL lo_load got %h/%h want 22", lo_a, lo_b); end
    wr_en = 2'b01; wr_addr[AW-1:0] = 5'd2; wr_data[DW-1:0] = 32'hA;
    tick();
    n_checks++; if (v0_a !== 32'hA || v0_b !== 32'hA) begin n_errors++; $display("FAIL v0_tap got %h/%h want a", v0_a, v0_b); end
    idle(); wr_en = 2'b01; wr_addr[AW-1:0] = 5'd4; wr_data[DW-1:0] = 32'hB;
    tick();
    n_checks++; if (a0_a !== 32'hB || a0_b !== 32'hB) begin n_errors++; $display("FAIL a0_tap got %h/%h want b", a0_a, a0_b); end
    idle();
  endtask

  task automatic test_random();
    logic [AW-1:0] wa [2];
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        wa[p] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
        wr_addr[p*AW +: AW] = wa[p];
        wr_data[p*DW +: DW] = $urandom;
        rd_addr[p*AW +: AW] = ($urandom_range(0, 1) == 1) ? wa[$urandom_range(0, 1)] : 5'($urandom);
      end
      wr_en = 2'($urandom); rd_en = 2'($urandom);
      hilo_we = ($urandom_range(0, 3) == 0); hi_in = $urandom; lo_in = $urandom;
      tick();
      for (int i = 0; i < 2; i++) begin
        n_checks++; if (rd_a[i*DW +: DW] !== erd_a[i]) begin n_errors++; $display("FAIL rand_rd_a%0d cyc %0d got %h want %h", i, c, rd_a[i*DW +: DW], erd_a[i]); end
        n_checks++; if (rd_b[i*DW +: DW] !== erd_b[i]) begin n_errors++; $display("FAIL rand_rd_b%0d cyc %0d got %h want %h", i, c, rd_b[i*DW +: DW], erd_b[i]); end
      end
      n_checks++; if (hi_a !== ehi || lo_a !== elo) begin n_errors++; $display("FAIL rand_hilo cyc %0d got %h/%h want %h/%h", c, hi_a, lo_a, ehi, elo); end
      n_checks++; if (a0_a !== ma[4] || v0_a !== ma[2]) begin n_errors++; $display("FAIL rand_taps_a cyc %0d got %h/%h want %h/%h", c, a0_a, v0_a, ma[4], ma[2]); end
      n_checks++; if (a0_b !== mb[4] || v0_b !== mb[2]) begin n_errors++; $display("FAIL rand_taps_b cyc %0d got %h/%h want %h/%h", c, a0_b, v0_b, mb[4], mb[2]); end
    end
    idle();
  endtask

  task automatic test_mid_reset();
    idle(); wr_en = 2'b01; wr_addr[AW-1:0] = 5'd3; wr_data[DW-1:0] = 32'h33;
    hilo_we = 1'b1; hi_in = 32'h5; lo_in = 32'h6; rd_en = 2'b11; rd_addr = {5'd5, 5'd5};
    tick();
    model_run = 1'b0;
    idle(); rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++; if (rd_a !== 64'h0 || rd_b !== 64'h0) begin n_errors++; $display("FAIL run_reset_rd got %h/%h want 0", rd_a, rd_b); end
    n_checks++; if (hi_a !== 32'h0 || lo_a !== 32'h0 || ready_a !== 1'b0) begin n_errors++; $display("FAIL run_reset_state got %h/%h/%b want 0/0/0", hi_a, lo_a, ready_a); end
    rst_n = 1'b1;
    wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {32'hFFFF, 32'hEEEE}; hilo_we = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); @(negedge clk);
      n_checks++; if (ready_a !== 1'b0) begin n_errors++; $display("FAIL mid_sweep_ready cycle %0d got %b want 0", k, ready_a); end
    end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); @(negedge clk);
      n_checks++; if (ready_a !== (k == 32)) begin n_errors++; $display("FAIL restart_ready_a cycle %0d got %b want %b", k, ready_a, (k == 32)); end
      n_checks++; if (ready_b !== (k == 32)) begin n_errors++; $display("FAIL restart_ready_b cycle %0d got %b want %b", k, ready_b, (k == 32)); end
    end
    idle(); model_clear(); model_run = 1'b1;
    rd_en = 2'b11; rd_addr = {5'd29, 5'd3};
    tick();
    n_checks++; if (rd_a[DW-1:0] !== 32'h0 || rd_b[DW-1:0] !== 32'h0) begin n_errors++; $display("FAIL clear_write_lost got %h/%h want 0", rd_a[DW-1:0], rd_b[DW-1:0]); end
    n_checks++; if (rd_a[2*DW-1:DW] !== SP) begin n_errors++; $display("FAIL restart_sp got %h want %h", rd_a[2*DW-1:DW], SP); end
    n_checks++; if (hi_a !== 32'h0 || lo_b !== 32'h0) begin n_errors++; $display("FAIL restart_hilo got %h/%h want 0/0", hi_a, lo_b); end
  endtask

  initial begin
    rst_n = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0; hi_in = '0; lo_in = '0;
    idle();
    @(negedge clk);
    test_reset();
    test_write_read();
    test_bypass();
    test_multiwrite();
    test_hilo_taps();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
